// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter.
// Operation codes and FSM states.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SWAP  = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SWAP_WR = 1'b1
    } state_t;

    // True for operations that read the array in their first cycle.
    function automatic logic op_reads(input logic [1:0] op);
        return (op == OP_READ) || (op == OP_SWAP);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector.
// On a tie the port that did not win last time is chosen.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] sel,
    output logic       valid
);

    logic last_grant;

    // Pick the single requester, or the non-last one on a tie.
    always_comb begin
        sel   = 2'b00;
        valid = |req;
        unique case (req)
            2'b01:   sel = 2'b01;
            2'b10:   sel = 2'b10;
            2'b11:   sel = last_grant ? 2'b01 : 2'b10;
            default: sel = 2'b00;
        endcase
    end

    // Remember the winner so port 0 takes the first tie after reset.
    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= 1'b1;
        else if (advance && valid)
            last_grant <= sel[1];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory.
// Handles range checks, READ/WRITE and two-cycle atomic SWAP.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int N = 32,
    parameter int M = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic         req1,
    input  logic [1:0]   op0,
    input  logic [1:0]   op1,
    input  logic [N-1:0] addr0,
    input  logic [N-1:0] addr1,
    input  logic [N-1:0] wdata0,
    input  logic [N-1:0] wdata1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         err0,
    output logic         err1,
    output logic         rvalid0,
    output logic         rvalid1,
    output logic [N-1:0] rdata0,
    output logic [N-1:0] rdata1,
    output logic [N-1:0] mem_address,
    output logic [N-1:0] mem_data_input,
    output logic         mem_memread,
    output logic         mem_memwrite,
    input  logic [N-1:0] mem_data
);

    state_t       state;
    state_t       state_nx;
    logic [1:0]   arb_req;
    logic [1:0]   sel;
    logic         valid;
    logic         advance;
    logic         port;
    logic [1:0]   cur_op;
    logic [N-1:0] cur_addr;
    logic [N-1:0] cur_wdata;
    logic         bad;
    logic         rd_issue;
    logic         swap_issue;
    logic [1:0]   rd_pend;
    logic         swap_port;
    logic [N-1:0] swap_addr;
    logic [N-1:0] swap_data;

    // Arbitration only runs while the memory is free.
    assign arb_req = (state == ST_IDLE && !reset) ? {req1, req0} : 2'b00;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (arb_req),
        .advance (advance),
        .sel     (sel),
        .valid   (valid)
    );

    assign port      = sel[1];
    assign cur_op    = port ? op1 : op0;
    assign cur_addr  = port ? addr1 : addr0;
    assign cur_wdata = port ? wdata1 : wdata0;
    assign bad       = ({1'b0, cur_addr} >= (N+1)'(M))
                     || (cur_op == OP_RSVD);

    // Next state and all per-cycle handshake and memory strobes.
    always_comb begin
        state_nx       = state;
        advance        = 1'b0;
        rd_issue       = 1'b0;
        swap_issue     = 1'b0;
        gnt0           = 1'b0;
        gnt1           = 1'b0;
        err0           = 1'b0;
        err1           = 1'b0;
        rvalid0        = 1'b0;
        rvalid1        = 1'b0;
        mem_address    = '0;
        mem_data_input = '0;
        mem_memread    = 1'b0;
        mem_memwrite   = 1'b0;
        if (reset) begin
            state_nx = ST_IDLE;
        end else begin
            {rvalid1, rvalid0} = rd_pend;
            unique case (state)
                ST_IDLE: begin
                    if (valid) begin
                        advance = 1'b1;
                        if (bad) begin
                            {err1, err0} = sel;
                        end else begin
                            {gnt1, gnt0} = sel;
                            mem_address  = cur_addr;
                            unique case (cur_op)
                                OP_READ: begin
                                    mem_memread = 1'b1;
                                    rd_issue    = 1'b1;
                                end
                                OP_WRITE: begin
                                    mem_memwrite   = 1'b1;
                                    mem_data_input = cur_wdata;
                                end
                                OP_SWAP: begin
                                    mem_memread = 1'b1;
                                    swap_issue  = 1'b1;
                                    state_nx    = ST_SWAP_WR;
                                end
                                default: mem_address = '0;
                            endcase
                        end
                    end
                end
                ST_SWAP_WR: begin
                    mem_memwrite   = 1'b1;
                    mem_address    = swap_addr;
                    mem_data_input = swap_data;
                    rvalid0        = rvalid0 | ~swap_port;
                    rvalid1        = rvalid1 | swap_port;
                    state_nx       = ST_IDLE;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // State, read capture, pending rvalid and latched swap operands.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rd_pend   <= 2'b00;
            rdata0    <= '0;
            rdata1    <= '0;
            swap_port <= 1'b0;
            swap_addr <= '0;
            swap_data <= '0;
        end else begin
            state   <= state_nx;
            rd_pend <= rd_issue ? sel : 2'b00;
            if (mem_memread && op_reads(cur_op)) begin
                if (sel[0])
                    rdata0 <= mem_data;
                if (sel[1])
                    rdata1 <= mem_data;
            end
            if (swap_issue) begin
                swap_port <= port;
                swap_addr <= cur_addr;
                swap_data <= cur_wdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic.
// A transaction-level model predicts every cycle's outputs.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [1:0]  op0, op1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, err0, err1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_address, mem_data_input, mem_data;
    logic        mem_memread, mem_memwrite;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];

    logic        m_last;
    logic        m_lock;
    logic        m_sport;
    logic [31:0] m_saddr, m_sdata, m_sold;
    logic [1:0]  m_pend;
    logic [31:0] m_pval [2];
    logic [31:0] exp_rd [2];

    logic [1:0]  o_gnt = 2'b00;
    logic [1:0]  o_err = 2'b00;
    logic [1:0]  o_rv  = 2'b00;

    dmem_arbiter #(.N(32), .M(256)) dut (
        .clk            (clk),
        .reset          (reset),
        .req0           (req0),
        .req1           (req1),
        .op0            (op0),
        .op1            (op1),
        .addr0          (addr0),
        .addr1          (addr1),
        .wdata0         (wdata0),
        .wdata1         (wdata1),
        .gnt0           (gnt0),
        .gnt1           (gnt1),
        .err0           (err0),
        .err1           (err1),
        .rvalid0        (rvalid0),
        .rvalid1        (rvalid1),
        .rdata0         (rdata0),
        .rdata1         (rdata1),
        .mem_address    (mem_address),
        .mem_data_input (mem_data_input),
        .mem_memread    (mem_memread),
        .mem_memwrite   (mem_memwrite),
        .mem_data       (mem_data)
    );

    always #5 clk = ~clk;

    assign mem_data = (mem_address < 32'd256) ? mem[mem_address[7:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_memwrite && mem_address < 32'd256)
            mem[mem_address[7:0]] <= mem_data_input;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input int p, input logic r, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            req0 = r; op0 = op; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; op1 = op; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic model_reset();
        m_last    = 1'b1;
        m_lock    = 1'b0;
        m_pend    = 2'b00;
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
    endtask

    // One clock: check outputs at negedge, advance model, return at posedge+1.
    task automatic step();
        logic [1:0]  eg, ee, ev;
        logic        emr, emw;
        logic [31:0] ea, ed;
        logic [31:0] rv_val [2];
        logic [1:0]  rq;
        logic [1:0]  wop;
        logic [31:0] wa, wd;
        logic        wbad;
        int          w;
        @(negedge clk);
        eg = 2'b00; ee = 2'b00; ev = 2'b00;
        emr = 1'b0; emw = 1'b0; ea = 32'h0; ed = 32'h0;
        rv_val[0] = 32'h0; rv_val[1] = 32'h0;
        w = -1; wop = 2'b00; wa = 32'h0; wd = 32'h0; wbad = 1'b0;
        if (!reset) begin
            for (int p = 0; p < 2; p++) begin
                if (m_pend[p]) begin
                    ev[p] = 1'b1;
                    rv_val[p] = m_pval[p];
                end
            end
            if (m_lock) begin
                ev[m_sport] = 1'b1;
                rv_val[m_sport] = m_sold;
                emw = 1'b1; ea = m_saddr; ed = m_sdata;
            end else begin
                rq = {req1, req0};
                if (rq == 2'b11)
                    w = m_last ? 0 : 1;
                else if (rq == 2'b01)
                    w = 0;
                else if (rq == 2'b10)
                    w = 1;
                if (w >= 0) begin
                    wop  = (w == 1) ? op1 : op0;
                    wa   = (w == 1) ? addr1 : addr0;
                    wd   = (w == 1) ? wdata1 : wdata0;
                    wbad = (wa >= 32'd256) || (wop == 2'b11);
                    if (wbad) begin
                        ee[w] = 1'b1;
                    end else begin
                        eg[w] = 1'b1;
                        ea = wa;
                        if (wop == 2'b01) begin
                            emw = 1'b1; ed = wd;
                        end else begin
                            emr = 1'b1;
                        end
                    end
                end
            end
        end
        check("gnt0", 32'(gnt0), 32'(eg[0]));
        check("gnt1", 32'(gnt1), 32'(eg[1]));
        check("err0", 32'(err0), 32'(ee[0]));
        check("err1", 32'(err1), 32'(ee[1]));
        check("rvalid0", 32'(rvalid0), 32'(ev[0]));
        check("rvalid1", 32'(rvalid1), 32'(ev[1]));
        check("memread", 32'(mem_memread), 32'(emr));
        check("memwrite", 32'(mem_memwrite), 32'(emw));
        check("mem_address", mem_address, ea);
        check("mem_data_input", mem_data_input, ed);
        o_gnt = {gnt1, gnt0};
        o_err = {err1, err0};
        o_rv  = {rvalid1, rvalid0};
        if (reset) begin
            model_reset();
        end else begin
            for (int p = 0; p < 2; p++)
                if (ev[p])
                    exp_rd[p] = rv_val[p];
            check("rdata0", rdata0, exp_rd[0]);
            check("rdata1", rdata1, exp_rd[1]);
            m_pend = 2'b00;
            if (m_lock) begin
                ref_mem[m_saddr[7:0]] = m_sdata;
                m_lock = 1'b0;
            end else if (w >= 0) begin
                m_last = (w == 1);
                if (!wbad) begin
                    if (wop == 2'b00) begin
                        m_pend[w] = 1'b1;
                        m_pval[w] = ref_mem[wa[7:0]];
                    end else if (wop == 2'b01) begin
                        ref_mem[wa[7:0]] = wd;
                    end else begin
                        m_lock  = 1'b1;
                        m_sport = (w == 1);
                        m_saddr = wa;
                        m_sdata = wd;
                        m_sold  = ref_mem[wa[7:0]];
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] r;
        logic [1:0]  nop;
        logic [31:0] na;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        model_reset();
        m_pval[0] = 32'h0; m_pval[1] = 32'h0;
        m_sport = 1'b0; m_saddr = 32'h0; m_sdata = 32'h0; m_sold = 32'h0;
        reset = 1'b1;
        drive(0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive(1, 1'b0, 2'b00, 32'h0, 32'h0);
        #1;
        step();
        step();
        reset = 1'b0;
        step();
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_rdata1", rdata1, 32'h0);

        // write then read back
        drive(0, 1'b1, 2'b01, 32'd5, 32'hDEADBEEF);
        step();
        check("wr5_gnt", 32'(o_gnt), 32'h1);
        drive(0, 1'b1, 2'b00, 32'd5, 32'h0);
        step();
        check("rd5_gnt", 32'(o_gnt), 32'h1);
        drive(0, 1'b0, 2'b00, 32'd0, 32'h0);
        step();
        check("rd5_rvalid", 32'(o_rv), 32'h1);
        check("rd5_data", rdata0, 32'hDEADBEEF);

        // both hold reads: grants alternate
        drive(0, 1'b1, 2'b00, 32'd1, 32'h0);
        drive(1, 1'b1, 2'b00, 32'd2, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("alt_onehot", 32'(o_gnt[0] ^ o_gnt[1]), 32'h1);
        end
        drive(0, 1'b0, 2'b00, 32'd0, 32'h0);
        drive(1, 1'b0, 2'b00, 32'd0, 32'h0);
        step();

        // range boundary on port 1
        drive(1, 1'b1, 2'b00, 32'd256, 32'h0);
        step();
        check("oor_err1", 32'(o_err), 32'h2);
        drive(1, 1'b1, 2'b00, 32'd255, 32'h0);
        step();
        check("edge_gnt1", 32'(o_gnt), 32'h2);
        drive(1, 1'b0, 2'b00, 32'd0, 32'h0);
        step();
        check("edge_rvalid1", 32'(o_rv), 32'h2);

        // swap while the other port reads the same word
        drive(1, 1'b1, 2'b01, 32'd7, 32'h11);
        step();
        drive(1, 1'b0, 2'b00, 32'd0, 32'h0);
        step();
        drive(0, 1'b1, 2'b10, 32'd7, 32'h22);
        drive(1, 1'b1, 2'b00, 32'd7, 32'h0);
        step();
        check("swap_gnt0", 32'(o_gnt), 32'h1);
        drive(0, 1'b0, 2'b00, 32'd0, 32'h0);
        step();
        check("swapwr_nognt", 32'(o_gnt), 32'h0);
        check("swapwr_rdata0", rdata0, 32'h11);
        step();
        check("after_swap_gnt1", 32'(o_gnt), 32'h2);
        drive(1, 1'b0, 2'b00, 32'd0, 32'h0);
        step();
        check("after_swap_rdata1", rdata1, 32'h22);

        // reset in the write half of a swap
        drive(0, 1'b1, 2'b01, 32'd9, 32'h5);
        step();
        drive(0, 1'b1, 2'b10, 32'd9, 32'h6);
        step();
        drive(0, 1'b0, 2'b00, 32'd0, 32'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(0, 1'b1, 2'b00, 32'd9, 32'h0);
        step();
        drive(0, 1'b0, 2'b00, 32'd0, 32'h0);
        step();
        check("rst_swap_rdata", rdata0, 32'h5);

        // reserved op still advances the round robin
        drive(0, 1'b1, 2'b11, 32'd3, 32'h0);
        step();
        check("rsvd_err0", 32'(o_err), 32'h1);
        drive(0, 1'b1, 2'b00, 32'd3, 32'h0);
        drive(1, 1'b1, 2'b00, 32'd4, 32'h0);
        step();
        check("rsvd_tie_gnt1", 32'(o_gnt), 32'h2);
        drive(1, 1'b0, 2'b00, 32'd0, 32'h0);
        step();
        drive(0, 1'b0, 2'b00, 32'd0, 32'h0);
        step();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (o_gnt[p] || o_err[p])
                    drive(p, 1'b0, 2'b00, 32'h0, 32'h0);
                if (((p == 0) ? req0 : req1) == 1'b0
                    && $urandom_range(0, 9) < 6) begin
                    r = $urandom_range(0, 19);
                    nop = (r == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                    r = $urandom_range(0, 19);
                    if (r == 0)
                        na = 32'd256 + $urandom_range(0, 3);
                    else if (r == 1)
                        na = 32'd255;
                    else if (r == 2)
                        na = $urandom;
                    else
                        na = $urandom_range(0, 15);
                    drive(p, 1'b1, nop, na, $urandom);
                end
            end
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        drive(0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive(1, 1'b0, 2'b00, 32'h0, 32'h0);
        step();
        step();
        for (int i = 0; i < 256; i++)
            check("mem_final", mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
